i2c_reg_master: RTL and testbench

Byte-oriented I2C master that performs one complete register transaction per request: a single-register write, or a single-register read with repeated START. It is the initiator counterpart of the FPGA's I2C register slave. The fabric uses it to program and poll external I2C peripherals, such as the HDMI transmitter, through open-drain SCL/SDA pads.

---
 rtl/i2c_reg_master.sv | 225 ++++++++++++++++++++++
 tb/tb_i2c_reg_master.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_master.sv
// rtl/i2c_reg_master.sv - I2C master performing one single-register write or read per request
//
// Purpose: on a start strobe, runs a complete I2C register transaction on
// open-drain SCL/SDA: write = {dev,0} reg data, read = {dev,0} reg
// RESTART {dev,1} then one received byte that the master NACKs. Every bit is
// four quarters of CLK_DIV clk cycles each. A slave NACK on any transmitted
// byte aborts straight to STOP and raises ack_error.
//
// Optional feature: define I2C_CLOCK_STRETCH_EN to honour slave clock
// stretching (the quarter counter waits at 0 while scl_in is low at the
// start of each SCL high phase). Undefined: scl_in is ignored.
//
// Ports:
//   clk, reset_n          system clock, asynchronous active-low reset
//   start                 request strobe, accepted only while idle
//   rw                    0 = write, 1 = read (captured with start)
//   dev_addr[6:0]         7-bit slave address (captured with start)
//   reg_addr[7:0]         register index (captured with start)
//   wr_data[7:0]          write payload (captured with start)
//   rd_data[7:0]          byte read by the last NACK-free read
//   busy                  transaction in progress
//   done                  one-cycle completion pulse
//   ack_error             a slave NACK occurred in the last transaction
//   scl_in, sda_in        pre-synchronised pad levels
//   scl_oe, sda_oe        1 = pull the line low, 0 = release

module i2c_reg_master #(
  parameter int CLK_DIV = 135
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       ack_error,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe
);

  localparam logic [15:0] CNT_MAX = 16'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SHIFT,
    S_ACK,
    S_RESTART,
    S_STOP
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_cnt;
  logic [1:0]  r_q;
  logic [2:0]  r_bit;
  logic [1:0]  r_byte;
  logic [7:0]  r_shift;
  logic        r_rw;
  logic [6:0]  r_dev;
  logic [7:0]  r_reg;
  logic [7:0]  r_wr;
  logic        r_done;
  logic        r_ack_error;
  logic [7:0]  r_rd_data;

  logic        w_accept;
  logic        w_qend;
  logic        w_bit_end;
  logic        w_tx;
  logic        w_nack;
  logic        w_hold;
  logic        w_enter_shift;
  logic [1:0]  w_next_byte;
  logic [7:0]  w_load_byte;
  logic        w_scl_oe;
  logic        w_sda_oe;

  // A start landing in the done cycle is dropped, not queued.
  assign w_accept  = (r_state == S_IDLE) && start && !r_done;
  assign w_qend    = (r_state != S_IDLE) && (r_cnt == CNT_MAX);
  assign w_bit_end = w_qend && (r_q == 2'd3);
  // Byte index 3 only exists in a read: it is the received data byte.
  assign w_tx      = !(r_rw && (r_byte == 2'd3));
  assign w_nack    = (r_state == S_ACK) && w_bit_end && w_tx && sda_in;

`ifdef I2C_CLOCK_STRETCH_EN
  // Hold at the first cycle of every SCL-high quarter until the line is
  // actually seen high, so the high phase is measured from the real edge.
  assign w_hold = (r_cnt == 16'd0) && !scl_in &&
                  ((((r_state == S_SHIFT) || (r_state == S_ACK)) && (r_q == 2'd2)) ||
                   (((r_state == S_RESTART) || (r_state == S_STOP)) && (r_q == 2'd1)));
`else
  logic w_unused_scl;
  assign w_unused_scl = scl_in;
  assign w_hold       = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_scl_oe    = 1'b0;
    w_sda_oe    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_START;
      end
      S_START: begin
        w_sda_oe = (r_q == 2'd1);
        if (w_qend && (r_q == 2'd1)) w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        w_scl_oe = (r_q < 2'd2);
        w_sda_oe = w_tx ? ~r_shift[7] : 1'b0;
        if (w_bit_end && (r_bit == 3'd7)) w_state_nxt = S_ACK;
      end
      S_ACK: begin
        // Master always releases SDA here: slave ACK slot, or our NACK.
        w_scl_oe = (r_q < 2'd2);
        if (w_bit_end) begin
          if (w_nack)                          w_state_nxt = S_STOP;
          else if (!r_rw && (r_byte == 2'd2))  w_state_nxt = S_STOP;
          else if (r_rw && (r_byte == 2'd1))   w_state_nxt = S_RESTART;
          else if (r_rw && (r_byte == 2'd3))   w_state_nxt = S_STOP;
          else                                 w_state_nxt = S_SHIFT;
        end
      end
      S_RESTART: begin
        w_scl_oe = (r_q == 2'd0);
        w_sda_oe = (r_q >= 2'd2);
        if (w_bit_end) w_state_nxt = S_SHIFT;
      end
      S_STOP: begin
        w_scl_oe = (r_q == 2'd0);
        w_sda_oe = (r_q <= 2'd1);
        if (w_bit_end) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_next_byte = (r_state == S_START) ? 2'd0 : r_byte + 2'd1;
    case (w_next_byte)
      2'd0:    w_load_byte = {r_dev, 1'b0};
      2'd1:    w_load_byte = r_reg;
      2'd2:    w_load_byte = r_rw ? {r_dev, 1'b1} : r_wr;
      default: w_load_byte = 8'h00;
    endcase
    w_enter_shift = w_qend && (w_state_nxt == S_SHIFT) && (r_state != S_SHIFT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt       <= 16'd0;
      r_q         <= 2'd0;
      r_bit       <= 3'd0;
      r_byte      <= 2'd0;
      r_shift     <= 8'h00;
      r_rw        <= 1'b0;
      r_dev       <= 7'h00;
      r_reg       <= 8'h00;
      r_wr        <= 8'h00;
      r_done      <= 1'b0;
      r_ack_error <= 1'b0;
      r_rd_data   <= 8'h00;
    end else begin
      r_done <= 1'b0;

      if (r_state == S_IDLE || w_hold || w_qend) r_cnt <= 16'd0;
      else                                         r_cnt <= r_cnt + 16'd1;

      // Quarter index restarts at 0 whenever the state changes, which also
      // covers START having only two quarters.
      if (w_accept)    r_q <= 2'd0;
      else if (w_qend) r_q <= (w_state_nxt != r_state) ? 2'd0 : r_q + 2'd1;

      if (w_accept) begin
        r_rw        <= rw;
        r_dev       <= dev_addr;
        r_reg       <= reg_addr;
        r_wr        <= wr_data;
        r_ack_error <= 1'b0;
      end

      // One shift path serves both directions; bits shifted in behind a
      // transmitted byte are simply never used.
      if ((r_state == S_SHIFT) && w_bit_end) begin
        r_bit   <= r_bit + 3'd1;
        r_shift <= {r_shift[6:0], sda_in};
      end

      if (w_enter_shift) begin
        r_byte  <= w_next_byte;
        r_shift <= w_load_byte;
        r_bit   <= 3'd0;
      end

      if (w_nack) r_ack_error <= 1'b1;

      if ((r_state == S_STOP) && w_bit_end) begin
        r_done <= 1'b1;
        if (r_rw && !r_ack_error) r_rd_data <= r_shift;
      end
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign ack_error = r_ack_error;
  assign rd_data   = r_rd_data;
  assign scl_oe    = w_scl_oe;
  assign sda_oe    = w_sda_oe;

endmodule

// File: tb/tb_i2c_reg_master.sv
// tb/tb_i2c_reg_master.sv - table-driven bench for i2c_reg_master with a behavioural slave

module tb_i2c_reg_master;

  localparam int CLK_DIV = 4;
`ifdef I2C_CLOCK_STRETCH_EN
  localparam int STRETCH_EXTRA = 50;
`else
  localparam int STRETCH_EXTRA = 0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       rw;
  logic [6:0] dev_addr;
  logic [7:0] reg_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       busy;
  logic       done;
  logic       ack_error;
  logic       scl_in;
  logic       sda_in;
  logic       scl_oe;
  logic       sda_oe;
  logic       s_scl_low = 1'b0;
  logic       s_sda_low = 1'b0;

  int cyc = 0;
  int n_vec = 0;
  int n_miss = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Wired-AND open-drain bus
  assign scl_in = ~(scl_oe | s_scl_low);
  assign sda_in = ~(sda_oe | s_sda_low);

  i2c_reg_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .rw(rw),
    .dev_addr(dev_addr), .reg_addr(reg_addr), .wr_data(wr_data),
    .rd_data(rd_data), .busy(busy), .done(done), .ack_error(ack_error),
    .scl_in(scl_in), .sda_in(sda_in), .scl_oe(scl_oe), .sda_oe(sda_oe)
  );

  typedef struct {
    logic       rw;
    logic [6:0] dev;
    logic [7:0] rg;
    logic [7:0] wd;
    logic [7:0] rx;
    int         nack_at;   // SCL pulse whose ACK the slave withholds (0 = none)
    bit         stretch;
    bit         poke;
    int         exp_bytes;
    logic [7:0] exp_b0;
    logic [7:0] exp_b1;
    logic [7:0] exp_b2;
    int         exp_pulses;
    int         exp_cycles;
    logic       exp_err;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(logic r, logic [6:0] d, logic [7:0] g, logic [7:0] w,
                              logic [7:0] x, int na, bit st, bit pk, int nb,
                              logic [7:0] b0, logic [7:0] b1, logic [7:0] b2,
                              int np, int nc, logic er, logic [7:0] rd);
    vec_t v;
    v.rw = r; v.dev = d; v.rg = g; v.wd = w; v.rx = x; v.nack_at = na;
    v.stretch = st; v.poke = pk; v.exp_bytes = nb;
    v.exp_b0 = b0; v.exp_b1 = b1; v.exp_b2 = b2;
    v.exp_pulses = np; v.exp_cycles = nc; v.exp_err = er; v.exp_rd = rd;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL v%0d %s: got 0x%0h, expected 0x%0h", idx, name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [0:63] bits;
    logic [7:0]  b;
    int          pc;
    int          hold;
    int          bcyc;
    int          dcyc;
    int          b2s;
    bit          prev;
    bit          fin;
    bits = '1; pc = 0; hold = 0; prev = 1'b0; fin = 1'b0; dcyc = 0;
    s_sda_low = 1'b0;
    s_scl_low = 1'b0;
    @(negedge clk);
    rw = v.rw; dev_addr = v.dev; reg_addr = v.rg; wr_data = v.wd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rw = ~v.rw; dev_addr = ~v.dev; reg_addr = ~v.rg; wr_data = ~v.wd;
    bcyc = cyc;
    check("busy_rise", idx, busy, 1);
    check("err_cleared", idx, ack_error, 0);
    for (int k = 0; k < 2000 && !fin; k++) begin
      @(negedge clk);
      start = (v.poke && (cyc - bcyc == 200));
      if (scl_oe && !prev) begin
        pc++;
        if (pc == 9 || pc == 18 || pc == (v.rw ? 28 : 27))
          s_sda_low = (pc != v.nack_at);
        else if (v.rw && pc >= 29 && pc <= 36)
          s_sda_low = ~v.rx[36 - pc];
        else
          s_sda_low = 1'b0;
      end else if (!scl_oe && prev) begin
        bits[pc] = sda_in;
      end
      if (v.stretch && scl_oe && pc == 13) hold = 51;
      else if (hold > 0)                   hold--;
      s_scl_low = (hold > 0);
      prev = scl_oe;
      if (done) begin
        fin  = 1'b1;
        dcyc = cyc;
        check("busy_at_done", idx, busy, 0);
        check("ack_error", idx, ack_error, v.exp_err);
        check("rd_data", idx, rd_data, v.exp_rd);
      end
    end
    s_sda_low = 1'b0;
    s_scl_low = 1'b0;
    if (!fin) begin
      check("done_timeout", idx, 0, 1);
    end else begin
      check("cycles", idx, dcyc - bcyc, v.exp_cycles);
      check("scl_pulses", idx, pc, v.exp_pulses);
      b = '0;
      for (int i = 0; i < 8; i++) b = {b[6:0], bits[1 + i]};
      check("byte0", idx, b, v.exp_b0);
      if (v.exp_bytes >= 2) begin
        for (int i = 0; i < 8; i++) b = {b[6:0], bits[10 + i]};
        check("byte1", idx, b, v.exp_b1);
      end
      if (v.exp_bytes >= 3) begin
        b2s = v.rw ? 20 : 19;
        for (int i = 0; i < 8; i++) b = {b[6:0], bits[b2s + i]};
        check("byte2", idx, b, v.exp_b2);
      end
      if (v.rw && !v.exp_err) check("master_nack", idx, bits[37], 1);
      if (v.poke) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("done_width", idx, done, 0);
      check("idle_after_done", idx, busy, 0);
      check("err_held", idx, ack_error, v.exp_err);
    end
  endtask

  task automatic reset_mid_shift();
    int pc;
    bit prev;
    bit hit;
    pc = 0; prev = 1'b0; hit = 1'b0;
    @(negedge clk);
    rw = 1'b0; dev_addr = 7'h39; reg_addr = 8'h41; wr_data = 8'h10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 400 && !hit; k++) begin
      @(negedge clk);
      if (scl_oe && !prev) pc++;
      prev = scl_oe;
      hit = (pc == 6) && scl_oe;
    end
    check("rst_reached_bit5", 100, hit, 1);
    check("rst_pre_scl_oe", 100, scl_oe, 1);
    check("rst_pre_sda_oe", 100, sda_oe, 1);
    reset_n = 1'b0;
    #1;
    check("rst_scl_oe", 100, scl_oe, 0);
    check("rst_sda_oe", 100, sda_oe, 0);
    check("rst_busy", 100, busy, 0);
    check("rst_done", 100, done, 0);
    check("rst_rd_data", 100, rd_data, 0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; rw = 1'b0;
    dev_addr = '0; reg_addr = '0; wr_data = '0;

    //             rw    dev    reg    wd     rx    nack st pk nb b0     b1     b2     pulses cycles            err   rd
    vecs[0] = mk(1'b0, 7'h39, 8'h41, 8'h10, 8'h00, 0,  0, 0, 3, 8'h72, 8'h41, 8'h10, 28, 456,               1'b0, 8'h00);
    vecs[1] = mk(1'b1, 7'h39, 8'h00, 8'h00, 8'hA5, 0,  0, 0, 3, 8'h72, 8'h00, 8'h73, 38, 616,               1'b0, 8'hA5);
    vecs[2] = mk(1'b0, 7'h39, 8'h41, 8'h10, 8'h00, 9,  0, 0, 1, 8'h72, 8'h00, 8'h00, 10, 168,               1'b1, 8'hA5);
    vecs[3] = mk(1'b1, 7'h50, 8'h0F, 8'h00, 8'hFF, 18, 0, 0, 2, 8'hA0, 8'h0F, 8'h00, 19, 312,               1'b1, 8'hA5);
    vecs[4] = mk(1'b1, 7'h50, 8'h0F, 8'h00, 8'h3C, 28, 0, 0, 3, 8'hA0, 8'h0F, 8'hA1, 29, 472,               1'b1, 8'hA5);
    vecs[5] = mk(1'b1, 7'h2A, 8'hC3, 8'h00, 8'h3C, 0,  0, 1, 3, 8'h54, 8'hC3, 8'h55, 38, 616,               1'b0, 8'h3C);
    vecs[6] = mk(1'b0, 7'h1D, 8'h96, 8'h5A, 8'h00, 0,  1, 0, 3, 8'h3A, 8'h96, 8'h5A, 28, 456 + STRETCH_EXTRA, 1'b0, 8'h00);
    vecs[7] = mk(1'b1, 7'h7F, 8'hFF, 8'h00, 8'h00, 0,  0, 0, 3, 8'hFE, 8'hFF, 8'hFF, 38, 616,               1'b0, 8'h00);

    repeat (3) @(negedge clk);
    check("reset_busy", 99, busy, 0);
    check("reset_done", 99, done, 0);
    check("reset_err", 99, ack_error, 0);
    check("reset_rd", 99, rd_data, 0);
    check("reset_scl_oe", 99, scl_oe, 0);
    check("reset_sda_oe", 99, sda_oe, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_scl_oe", 99, scl_oe, 0);
    check("idle_sda_oe", 99, sda_oe, 0);

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);
    reset_mid_shift();
    for (int i = 6; i < 8; i++) run_vec(i, vecs[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
